serial_cmd_frame_decoder: RTL and testbench

//  Parametrised command-frame decoder between the UART RX byte FIFO and the command executor.

---
 rtl/serial_cmd_frame_decoder_pkg.sv | 38 +++
 rtl/serial_cmd_frame_decoder_payload_bank.sv | 33 +++
 rtl/serial_cmd_frame_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_serial_cmd_frame_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_frame_decoder_pkg.sv
// Shared types and constants for the serial command-frame decoder.
package serial_cmd_frame_decoder_pkg;

    // Controller states: a symbol costs one POP cycle plus one SAMPLE cycle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Position inside the frame that the next sampled symbol is checked against.
    typedef enum logic [2:0] {
        PH_SOF     = 3'd0,
        PH_SEP1    = 3'd1,
        PH_PAYLOAD = 3'd2,
        PH_EOF     = 3'd3,
        PH_FLUSH   = 3'd4
    } phase_e;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_NO_SOF   = 3'd1;
    localparam logic [2:0] ERR_NO_SEP   = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_NO_EOF   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    localparam logic [7:0] DEF_SOF_SYMBOL = 8'h7B;  // '{'
    localparam logic [7:0] DEF_SEP_SYMBOL = 8'h20;  // ' '
    localparam logic [7:0] DEF_EOF_SYMBOL = 8'h7D;  // '}'

    // Byte counter increment that sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/serial_cmd_frame_decoder_payload_bank.sv
// Payload register bank: MAX_PAYLOAD symbols, cleared as a whole, written one slot at a time.
module serial_cmd_payload_bank #(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PAYLOAD = 8,
    parameter int IDX_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr_i,
    input  logic                              we_i,
    input  logic [IDX_W-1:0]                  idx_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] payload_o
);

    logic [DATA_WIDTH-1:0] slot_q [MAX_PAYLOAD];

    // Clear on reset or frame start; otherwise write the addressed slot only.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (rst || clr_i) begin
                slot_q[k] <= '0;
            end else if (we_i && (idx_i == IDX_W'(k))) begin
                slot_q[k] <= wdata_i;
            end
        end
    end

    for (genvar g = 0; g < MAX_PAYLOAD; g++) begin : g_flat
        assign payload_o[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end

endmodule

// File: rtl/serial_cmd_frame_decoder.sv
// Command-frame decoder: pops SOF SEP payload SEP EOF from the RX FIFO, latches the
// payload, reports a status code and holds the result until the consumer acknowledges.
module serial_cmd_frame_decoder
    import serial_cmd_frame_decoder_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    MAX_PAYLOAD    = 8,
    parameter logic [DATA_WIDTH-1:0] SOF_SYMBOL     = DATA_WIDTH'(DEF_SOF_SYMBOL),
    parameter logic [DATA_WIDTH-1:0] SEP_SYMBOL     = DATA_WIDTH'(DEF_SEP_SYMBOL),
    parameter logic [DATA_WIDTH-1:0] EOF_SYMBOL     = DATA_WIDTH'(DEF_EOF_SYMBOL),
    parameter int                    TIMEOUT_CYCLES = 1000,
    localparam int                   LEN_W          = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_ready,
    input  logic                              fifo_empty,
    input  logic [DATA_WIDTH-1:0]             data,
    input  logic                              cmd_processed_received,
    output logic                              cmd_read_clk,
    output logic                              cmd_processed,
    output logic                              cmd_decode_success,
    output logic [2:0]                        cmd_error_code,
    output logic [7:0]                        cmd_bytes_processed,
    output logic [LEN_W-1:0]                  cmd_payload_len,
    output logic [MAX_PAYLOAD*DATA_WIDTH-1:0] cmd_payload
);

    // Stall counter only has to reach TIMEOUT_CYCLES-1.
    localparam int  STALL_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [LEN_W-1:0]   len_q,   len_d;
    logic [7:0]         bytes_q, bytes_d;
    logic [2:0]         err_q,   err_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic bank_clr;
    logic bank_we;
    logic pop;

    // State, phase and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SOF;
            len_q   <= '0;
            bytes_q <= '0;
            err_q   <= ERR_OK;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            len_q   <= len_d;
            bytes_q <= bytes_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic: frame checking, flushing, timeout and result handshake.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        bytes_d  = bytes_q;
        err_d    = err_q;
        stall_d  = stall_q;
        bank_clr = 1'b0;
        bank_we  = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_ready && !fifo_empty) begin
                    bank_clr = 1'b1;
                    len_d    = '0;
                    bytes_d  = '0;
                    err_d    = ERR_OK;
                    stall_d  = '0;
                    phase_d  = PH_SOF;
                    state_d  = ST_POP;
                end
            end

            ST_POP: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    stall_d = '0;
                    state_d = ST_SAMPLE;
                end else if (TIMEOUT_EN && (stall_q == STALL_LIMIT)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end

            ST_SAMPLE: begin
                bytes_d = sat_inc8(bytes_q);
                unique case (phase_q)
                    PH_SOF: begin
                        if (data == SOF_SYMBOL) begin
                            phase_d = PH_SEP1;
                            state_d = ST_POP;
                        end else begin
                            err_d   = ERR_NO_SOF;
                            phase_d = PH_FLUSH;
                            state_d = ST_FLUSH;
                        end
                    end
                    PH_SEP1: begin
                        if (data == SEP_SYMBOL) begin
                            phase_d = PH_PAYLOAD;
                            state_d = ST_POP;
                        end else begin
                            err_d   = ERR_NO_SEP;
                            phase_d = PH_FLUSH;
                            state_d = ST_FLUSH;
                        end
                    end
                    PH_PAYLOAD: begin
                        if (data == SEP_SYMBOL) begin
                            phase_d = PH_EOF;
                            state_d = ST_POP;
                        end else if (data == EOF_SYMBOL) begin
                            // Frame closed without the trailing separator; nothing left to flush.
                            err_d   = ERR_NO_SEP;
                            state_d = ST_DONE;
                        end else if (len_q == LEN_W'(MAX_PAYLOAD)) begin
                            err_d   = ERR_OVERFLOW;
                            phase_d = PH_FLUSH;
                            state_d = ST_FLUSH;
                        end else begin
                            bank_we = 1'b1;
                            len_d   = len_q + LEN_W'(1);
                            state_d = ST_POP;
                        end
                    end
                    PH_EOF: begin
                        if (data == EOF_SYMBOL) begin
                            state_d = ST_DONE;
                        end else begin
                            err_d   = ERR_NO_EOF;
                            phase_d = PH_FLUSH;
                            state_d = ST_FLUSH;
                        end
                    end
                    PH_FLUSH: begin
                        state_d = (data == EOF_SYMBOL) ? ST_DONE : ST_FLUSH;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            ST_FLUSH: begin
                // An empty FIFO ends the flush rather than stalling.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (cmd_processed_received) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    serial_cmd_payload_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MAX_PAYLOAD (MAX_PAYLOAD),
        .IDX_W       (LEN_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (bank_clr),
        .we_i      (bank_we),
        .idx_i     (len_q),
        .wdata_i   (data),
        .payload_o (cmd_payload)
    );

    // Pop strobe is suppressed while reset is held so an aborted frame never pops.
    assign cmd_read_clk        = pop & ~rst;
    assign cmd_processed       = (state_q == ST_DONE);
    assign cmd_decode_success  = (state_q == ST_DONE) && (err_q == ERR_OK);
    assign cmd_error_code      = err_q;
    assign cmd_bytes_processed = bytes_q;
    assign cmd_payload_len     = len_q;

endmodule

// File: tb/tb_serial_cmd_frame_decoder.sv
// Bench for serial_cmd_frame_decoder: FIFO model, stream-level reference decoder, scoreboard.
module tb_serial_cmd_frame_decoder;

    localparam int DW   = 8;
    localparam int MAXP = 8;
    localparam int TMO  = 50;
    localparam int LW   = $clog2(MAXP + 1);
    localparam logic [7:0] SOF  = 8'h7B;
    localparam logic [7:0] SEP  = 8'h20;
    localparam logic [7:0] EOFS = 8'h7D;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_ready = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [DW-1:0]    data = '0;
    logic             ack;
    logic             ack_hold = 1'b0;
    logic             ack_pulse = 1'b0;
    logic             cmd_read_clk;
    logic             cmd_processed;
    logic             cmd_decode_success;
    logic [2:0]       cmd_error_code;
    logic [7:0]       cmd_bytes_processed;
    logic [LW-1:0]    cmd_payload_len;
    logic [MAXP*DW-1:0] cmd_payload;

    assign ack = ack_hold | ack_pulse;

    serial_cmd_frame_decoder #(
        .DATA_WIDTH     (DW),
        .MAX_PAYLOAD    (MAXP),
        .SOF_SYMBOL     (SOF),
        .SEP_SYMBOL     (SEP),
        .EOF_SYMBOL     (EOFS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_ready              (cmd_ready),
        .fifo_empty             (fifo_empty),
        .data                   (data),
        .cmd_processed_received (ack),
        .cmd_read_clk           (cmd_read_clk),
        .cmd_processed          (cmd_processed),
        .cmd_decode_success     (cmd_decode_success),
        .cmd_error_code         (cmd_error_code),
        .cmd_bytes_processed    (cmd_bytes_processed),
        .cmd_payload_len        (cmd_payload_len),
        .cmd_payload            (cmd_payload)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  err;
        int          len;
        int          bytes;
        logic [63:0] payload;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fifo_q[$];
    logic [7:0]  mq[$];
    exp_t        sb[$];
    int          ready_mode = 0;   // 0: auto (a whole frame queued), 1: forced low, 2: forced high
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          done_cyc = 0;
    int          pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit fifo_has_eof();
        foreach (fifo_q[i]) if (fifo_q[i] == EOFS) return 1'b1;
        return 1'b0;
    endfunction

    // Reference decoder over the byte stream: consumes one frame's worth of symbols.
    task automatic model_next(output exp_t e);
        logic [7:0] b;
        int  phase;   // 0 SOF, 1 first SEP, 2 payload, 3 EOF
        bit  flushing;
        bit  fin;
        e = '{err: 3'd0, len: 0, bytes: 0, payload: 64'd0};
        phase = 0;
        flushing = 1'b0;
        fin = 1'b0;
        while (!fin) begin
            if (mq.size() == 0) begin
                if (!flushing) e.err = 3'd5;
                fin = 1'b1;
            end else begin
                b = mq.pop_front();
                if (e.bytes < 255) e.bytes++;
                if (flushing) begin
                    if (b == EOFS) fin = 1'b1;
                end else if (phase == 0) begin
                    if (b == SOF) phase = 1;
                    else begin e.err = 3'd1; flushing = 1'b1; end
                end else if (phase == 1) begin
                    if (b == SEP) phase = 2;
                    else begin e.err = 3'd2; flushing = 1'b1; end
                end else if (phase == 2) begin
                    if (b == SEP) phase = 3;
                    else if (b == EOFS) begin e.err = 3'd2; fin = 1'b1; end
                    else if (e.len == MAXP) begin e.err = 3'd3; flushing = 1'b1; end
                    else begin e.payload[e.len*8 +: 8] = b; e.len++; end
                end else begin
                    if (b == EOFS) fin = 1'b1;
                    else begin e.err = 3'd4; flushing = 1'b1; end
                end
            end
        end
    endtask

    task automatic model_drain();
        exp_t e;
        while (mq.size() > 0) begin
            model_next(e);
            sb.push_back(e);
        end
    endtask

    task automatic pb(input logic [7:0] b);
        fifo_q.push_back(b);
        mq.push_back(b);
    endtask

    task automatic push_str(input string s, input bit to_model);
        for (int i = 0; i < s.len(); i++) begin
            fifo_q.push_back(s[i]);
            if (to_model) mq.push_back(s[i]);
        end
    endtask

    task automatic gen_frame();
        int kind;
        int n;
        logic [7:0] b;
        kind = $urandom_range(0, 9);
        n    = $urandom_range(0, 10);
        pb((kind == 0) ? 8'($urandom_range(48, 90)) : SOF);
        pb((kind == 1) ? 8'h51 : SEP);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(33, 126));
            if (b == SEP || b == EOFS) b = 8'h41;
            pb(b);
        end
        if (kind != 2) pb(SEP);
        if (kind == 3) pb(8'h5A);
        pb(EOFS);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((sb.size() != 0 || fifo_q.size() != 0 || cmd_processed || ack_pulse) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(n < bound), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    // FIFO model: pops on the strobe, data valid from just after the popping edge.
    initial begin
        bit popped;
        forever begin
            @(negedge clk);
            popped = (cmd_read_clk === 1'b1);
            if (popped) begin
                check("pop_while_empty", 64'(fifo_empty), 64'd0);
                pops++;
                last_pop_cyc = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (popped && fifo_q.size() > 0) data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            cmd_ready  = (ready_mode == 2) || (ready_mode == 0 && fifo_has_eof());
        end
    end

    // Monitor: compares each presented result with the scoreboard, then acknowledges.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            if (!rst && cmd_processed) begin
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: err=%0d with no frame outstanding", cmd_error_code);
                    e = '{err: cmd_error_code, len: 0, bytes: 0, payload: 64'd0};
                end else begin
                    e = sb.pop_front();
                    check("err_code", 64'(cmd_error_code), 64'(e.err));
                    check("success", 64'(cmd_decode_success), 64'(e.err == 3'd0));
                    check("payload_len", 64'(cmd_payload_len), 64'(e.len));
                    check("bytes_processed", 64'(cmd_bytes_processed), 64'(e.bytes));
                    check("payload", cmd_payload, e.payload);
                end
                if (ack_hold) begin
                    @(negedge clk);
                    check("drop_after_held_ack", 64'(cmd_processed), 64'd0);
                end else begin
                    d = $urandom_range(0, 3);
                    repeat (d) begin
                        @(negedge clk);
                        check("result_held", 64'(cmd_processed), 64'd1);
                        check("err_stable", 64'(cmd_error_code), 64'(e.err));
                    end
                    ack_pulse = 1'b1;
                    @(negedge clk);
                    ack_pulse = 1'b0;
                    check("drop_after_ack", 64'(cmd_processed), 64'd0);
                    check("success_drop", 64'(cmd_decode_success), 64'd0);
                end
            end
        end
    end

    // Stimulus: directed frames, timeout, idle gating, mid-frame reset, then random batches.
    initial begin
        int p0;
        int n;

        repeat (3) @(negedge clk);
        check("rst_read_clk", 64'(cmd_read_clk), 64'd0);
        check("rst_processed", 64'(cmd_processed), 64'd0);
        check("rst_success", 64'(cmd_decode_success), 64'd0);
        check("rst_err", 64'(cmd_error_code), 64'd0);
        check("rst_bytes", 64'(cmd_bytes_processed), 64'd0);
        check("rst_len", 64'(cmd_payload_len), 64'd0);
        check("rst_payload", cmd_payload, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        push_str("{ 0123 }", 1'b1);               model_drain(); wait_idle(300);
        push_str("{ AB }{ 12345678 }", 1'b1);     model_drain(); wait_idle(300);
        push_str("X 12 }{ 9 }", 1'b1);            model_drain(); wait_idle(300);
        push_str("{12}", 1'b1);                   model_drain(); wait_idle(300);
        push_str("{ 123456789 }", 1'b1);          model_drain(); wait_idle(300);
        push_str("{  }", 1'b1);                   model_drain(); wait_idle(300);
        push_str("{ 1}", 1'b1);                   model_drain(); wait_idle(300);
        push_str("{ 1 X}", 1'b1);                 model_drain(); wait_idle(300);

        pb(8'h58);
        for (int i = 0; i < 300; i++) pb(8'h61);
        pb(EOFS);
        model_drain(); wait_idle(2000);

        ack_hold = 1'b1;
        push_str("{ 77 }", 1'b1); model_drain(); wait_idle(300);
        ack_hold = 1'b0;
        @(negedge clk);

        ready_mode = 2;
        push_str("{ 12", 1'b1); model_drain(); wait_idle(400);
        check("timeout_latency", 64'(done_cyc - last_pop_cyc), 64'(TMO + 2));

        ready_mode = 1;
        p0 = pops;
        push_str(" }", 1'b1);
        repeat (10) @(negedge clk);
        check("idle_needs_ready_pops", 64'(pops - p0), 64'd0);
        check("idle_needs_ready_fifo", 64'(fifo_q.size()), 64'd2);
        check("idle_needs_ready_proc", 64'(cmd_processed), 64'd0);
        model_drain();
        ready_mode = 0;
        wait_idle(300);

        ready_mode = 2;
        p0 = pops;
        push_str("{ 123", 1'b0);
        n = 0;
        while (pops < p0 + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midframe_progress", 64'(n < 100), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_read_clk", 64'(cmd_read_clk), 64'd0);
        check("mrst_processed", 64'(cmd_processed), 64'd0);
        check("mrst_err", 64'(cmd_error_code), 64'd0);
        check("mrst_bytes", 64'(cmd_bytes_processed), 64'd0);
        check("mrst_len", 64'(cmd_payload_len), 64'd0);
        check("mrst_payload", cmd_payload, 64'd0);
        fifo_q.delete();
        ready_mode = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int batch = 0; batch < 15; batch++) begin
            ack_hold = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            n = $urandom_range(1, 3);
            for (int f = 0; f < n; f++) gen_frame();
            model_drain();
            wait_idle(3000);
            ack_hold = 1'b0;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
